// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit computer control path.
//   - opcode constants (load/store, ALU, branch)
//   - Bus1 / Bus2 select encodings
//   - control-unit state enum and registered control word
//   - NZVC bit indices into CCR_Result
//   - opcode classification helpers
// Optional feature macro: CU_HALT_EN (adds HALT opcode 0x00, S_HALT state
// and the halted flag to the control word).
package cpu_pkg;

  // Load / store (one operand byte each)
  localparam logic [7:0] LDA_IMM = 8'h86;
  localparam logic [7:0] LDA_DIR = 8'h87;
  localparam logic [7:0] LDB_IMM = 8'h88;
  localparam logic [7:0] LDB_DIR = 8'h89;
  localparam logic [7:0] STA_DIR = 8'h96;
  localparam logic [7:0] STB_DIR = 8'h97;

  // ALU operations; the low nibble is the ALU select code
  localparam logic [7:0] ADD_AB  = 8'h42;
  localparam logic [7:0] SUB_AB  = 8'h43;
  localparam logic [7:0] AND_AB  = 8'h44;
  localparam logic [7:0] OR_AB   = 8'h45;
  localparam logic [7:0] INCA    = 8'h46;
  localparam logic [7:0] INCB    = 8'h47;
  localparam logic [7:0] DECA    = 8'h48;
  localparam logic [7:0] DECB    = 8'h49;
  localparam logic [7:0] XOR_AB  = 8'h4A;
  localparam logic [7:0] NOTA    = 8'h4B;
  localparam logic [7:0] NOTB    = 8'h4C;

  // Branches (one target-address operand byte each)
  localparam logic [7:0] BRA     = 8'h20;
  localparam logic [7:0] BMI     = 8'h21;
  localparam logic [7:0] BPL     = 8'h22;
  localparam logic [7:0] BEQ     = 8'h23;
  localparam logic [7:0] BNE     = 8'h24;
  localparam logic [7:0] BVS     = 8'h25;
  localparam logic [7:0] BVC     = 8'h26;
  localparam logic [7:0] BCS     = 8'h27;
  localparam logic [7:0] BCC     = 8'h28;

  localparam logic [7:0] HALT_OP = 8'h00;

  // Bus select encodings
  localparam logic [1:0] BUS1_PC   = 2'd0;
  localparam logic [1:0] BUS1_A    = 2'd1;
  localparam logic [1:0] BUS1_B    = 2'd2;
  localparam logic [1:0] BUS2_ALU  = 2'd0;
  localparam logic [1:0] BUS2_BUS1 = 2'd1;
  localparam logic [1:0] BUS2_MEM  = 2'd2;

  // Bit positions of the flags in CCR_Result = {N,Z,V,C}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [3:0] {
    S_FETCH_0,
    S_FETCH_1,
    S_FETCH_2,
    S_DECODE_3,
    S_OPR_4,
    S_OPR_5,
    S_IMM_6,
    S_DIR_6,
    S_DIR_7,
    S_DIR_8,
    S_BR_6,
    S_BRSKIP_4,
    S_ALU_4
`ifdef CU_HALT_EN
    , S_HALT
`endif
  } state_t;

  // Registered control word, one field per datapath control
  typedef struct packed {
    logic       ir_load;
    logic       mar_load;
    logic       pc_load;
    logic       pc_inc;
    logic       a_load;
    logic       b_load;
    logic       ccr_load;
    logic [3:0] alu_sel;
    logic [1:0] bus1_sel;
    logic [1:0] bus2_sel;
    logic       write;
`ifdef CU_HALT_EN
    logic       halted;
`endif
  } ctrl_t;

  function automatic logic is_imm(input logic [7:0] op);
    return (op == LDA_IMM) || (op == LDB_IMM);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == STA_DIR) || (op == STB_DIR);
  endfunction

  function automatic logic is_ldst(input logic [7:0] op);
    return is_imm(op) || is_store(op) || (op == LDA_DIR) || (op == LDB_DIR);
  endfunction

  function automatic logic is_alu(input logic [7:0] op);
    return (op >= ADD_AB) && (op <= NOTB);
  endfunction

  function automatic logic is_branch(input logic [7:0] op);
    return (op >= BRA) && (op <= BCC);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition evaluation.
// Ports:
//   IR          in  instruction register contents (branch opcode)
//   CCR_Result  in  {N,Z,V,C} condition flags
//   taken       out 1 when IR is a branch whose condition holds
// Non-branch opcodes always give taken=0.
module branch_cond_eval
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] IR,
  input  logic [3:0]        CCR_Result,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (IR[7:0])
      BRA:     taken = 1'b1;
      BMI:     taken =  CCR_Result[FLAG_N];
      BPL:     taken = ~CCR_Result[FLAG_N];
      BEQ:     taken =  CCR_Result[FLAG_Z];
      BNE:     taken = ~CCR_Result[FLAG_Z];
      BVS:     taken =  CCR_Result[FLAG_V];
      BVC:     taken = ~CCR_Result[FLAG_V];
      BCS:     taken =  CCR_Result[FLAG_C];
      BCC:     taken = ~CCR_Result[FLAG_C];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute FSM of the 8-bit computer.
// Ports:
//   clk, reset (async, active-low)
//   IR          in  instruction register contents
//   CCR_Result  in  {N,Z,V,C} flags, sampled while in S_DECODE_3
//   IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
//   ALU_Sel, Bus1_Sel, Bus2_Sel, write  out  registered datapath controls
//   halted      out CPU halted (only with CU_HALT_EN, otherwise 0)
// Optional feature macro: CU_HALT_EN (opcode 0x00 enters S_HALT until reset).
//
// Outputs are registered: on each edge the control word for the state being
// entered is computed, so outputs always match the current state.
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ALU_SEL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    IR,
  input  logic [3:0]           CCR_Result,
  output logic                 IR_Load,
  output logic                 MAR_Load,
  output logic                 PC_Load,
  output logic                 PC_Inc,
  output logic                 A_Load,
  output logic                 B_Load,
  output logic                 CCR_Load,
  output logic [ALU_SEL_W-1:0] ALU_Sel,
  output logic [1:0]           Bus1_Sel,
  output logic [1:0]           Bus2_Sel,
  output logic                 write,
  output logic                 halted
);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl_q;
  logic [7:0] op;
  logic       taken;

  assign op = IR[7:0];

  branch_cond_eval #(.DATA_W(DATA_W)) u_branch (
    .IR         (IR),
    .CCR_Result (CCR_Result),
    .taken      (taken)
  );

  function automatic ctrl_t decode_ctrl(input state_t s, input logic [7:0] opc);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH_0, S_OPR_4: begin
        c.bus1_sel = BUS1_PC;
        c.bus2_sel = BUS2_BUS1;
        c.mar_load = 1'b1;
      end
      S_FETCH_1:  c.pc_inc = 1'b1;
      S_FETCH_2: begin
        c.bus2_sel = BUS2_MEM;
        c.ir_load  = 1'b1;
      end
      // A taken branch keeps PC on its operand; the target is loaded later.
      S_OPR_5:    c.pc_inc = ~is_branch(opc);
      S_IMM_6: begin
        c.bus2_sel = BUS2_MEM;
        c.a_load   = (opc == LDA_IMM);
        c.b_load   = (opc == LDB_IMM);
      end
      S_DIR_6: begin
        c.bus2_sel = BUS2_MEM;
        c.mar_load = 1'b1;
      end
      S_DIR_7: begin
        if (is_store(opc)) begin
          c.bus1_sel = (opc == STA_DIR) ? BUS1_A : BUS1_B;
          c.write    = 1'b1;
        end
      end
      S_DIR_8: begin
        c.bus2_sel = BUS2_MEM;
        c.a_load   = (opc == LDA_DIR);
        c.b_load   = (opc == LDB_DIR);
      end
      S_BR_6: begin
        c.bus2_sel = BUS2_MEM;
        c.pc_load  = 1'b1;
      end
      S_BRSKIP_4: c.pc_inc = 1'b1;
      S_ALU_4: begin
        c.alu_sel  = opc[3:0];
        c.bus2_sel = BUS2_ALU;
        c.ccr_load = 1'b1;
        if ((opc == INCB) || (opc == DECB) || (opc == NOTB)) begin
          c.bus1_sel = BUS1_B;
          c.b_load   = 1'b1;
        end else begin
          c.bus1_sel = BUS1_A;
          c.a_load   = 1'b1;
        end
      end
`ifdef CU_HALT_EN
      S_HALT:     c.halted = 1'b1;
`endif
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = S_FETCH_0;
    case (state)
      // Reset leaves S_FETCH_0 with all outputs cleared; the first edge after
      // release re-enters S_FETCH_0 so the opening MAR load is really issued.
      S_FETCH_0:  state_nxt = ctrl_q.mar_load ? S_FETCH_1 : S_FETCH_0;
      S_FETCH_1:  state_nxt = S_FETCH_2;
      S_FETCH_2:  state_nxt = S_DECODE_3;
      S_DECODE_3: begin
        if (is_ldst(op))        state_nxt = S_OPR_4;
        else if (is_alu(op))    state_nxt = S_ALU_4;
        else if (is_branch(op)) state_nxt = taken ? S_OPR_4 : S_BRSKIP_4;
        else                    state_nxt = S_FETCH_0;
`ifdef CU_HALT_EN
        if (op == HALT_OP)      state_nxt = S_HALT;
`endif
      end
      S_OPR_4:    state_nxt = S_OPR_5;
      S_OPR_5: begin
        if (is_branch(op))      state_nxt = S_BR_6;
        else if (is_imm(op))    state_nxt = S_IMM_6;
        else                    state_nxt = S_DIR_6;
      end
      S_DIR_6:    state_nxt = S_DIR_7;
      S_DIR_7:    state_nxt = is_store(op) ? S_FETCH_0 : S_DIR_8;
`ifdef CU_HALT_EN
      S_HALT:     state_nxt = S_HALT;
`endif
      default:    state_nxt = S_FETCH_0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH_0;
      ctrl_q <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= decode_ctrl(state_nxt, op);
    end
  end

  assign IR_Load  = ctrl_q.ir_load;
  assign MAR_Load = ctrl_q.mar_load;
  assign PC_Load  = ctrl_q.pc_load;
  assign PC_Inc   = ctrl_q.pc_inc;
  assign A_Load   = ctrl_q.a_load;
  assign B_Load   = ctrl_q.b_load;
  assign CCR_Load = ctrl_q.ccr_load;
  assign ALU_Sel  = ALU_SEL_W'(ctrl_q.alu_sel);
  assign Bus1_Sel = ctrl_q.bus1_sel;
  assign Bus2_Sel = ctrl_q.bus2_sel;
  assign write    = ctrl_q.write;
`ifdef CU_HALT_EN
  assign halted   = ctrl_q.halted;
`else
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed bench for control_unit. A small behavioural
// datapath (PC, MAR, IR, A, B, 256-byte memory with 1-cycle read latency)
// executes a hand-written program; expected values are hand-computed.
module tb_control_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir_q;
  logic [3:0] ccr;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [3:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic       write, halted;

  always #5 clk = ~clk;

  control_unit #(.DATA_W(8), .ALU_SEL_W(4)) dut (
    .clk(clk), .reset(reset), .IR(ir_q), .CCR_Result(ccr),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write), .halted(halted)
  );

  // Behavioural datapath
  logic [7:0] mem [256];
  logic [7:0] pc, mar, a, b, from_memory, bus1, bus2, alu;

  always_comb begin
    case (ALU_Sel)
      4'd2:    alu = a + b;
      4'd3:    alu = a - b;
      default: alu = a;
    endcase
    case (Bus1_Sel)
      2'd0:    bus1 = pc;
      2'd1:    bus1 = a;
      2'd2:    bus1 = b;
      default: bus1 = 8'h00;
    endcase
    case (Bus2_Sel)
      2'd0:    bus2 = alu;
      2'd1:    bus2 = bus1;
      2'd2:    bus2 = from_memory;
      default: bus2 = 8'h00;
    endcase
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= 8'h00; mar <= 8'h00; ir_q <= 8'h00;
      a <= 8'h00; b <= 8'h00; from_memory <= 8'h00;
    end else begin
      from_memory <= mem[mar];
      if (write) mem[mar] = bus1;
      if (MAR_Load) mar <= bus2;
      if (PC_Load) pc <= bus2;
      else if (PC_Inc) pc <= pc + 8'd1;
      if (IR_Load) ir_q <= bus2;
      if (A_Load) a <= bus2;
      if (B_Load) b <= bus2;
    end
  end

  // Per-cycle log of one instruction
  typedef struct packed {
    logic ir_l, mar_l, pc_l, pc_i, a_l, b_l, ccr_l, wr, hlt;
    logic [3:0] alu;
    logic [1:0] b1, b2;
    logic [7:0] mar;
  } obs_t;

  obs_t lg [20];
  int   n_cyc;
  int   n_assert = 0;
  int   n_fail = 0;

  // Branch vectors {opcode, NZVC, expected taken}
  localparam logic [12:0] BV [18] = '{
    {8'h20, 4'b0000, 1'b1}, {8'h20, 4'b1111, 1'b1},
    {8'h21, 4'b1000, 1'b1}, {8'h21, 4'b0111, 1'b0},
    {8'h22, 4'b0111, 1'b1}, {8'h22, 4'b1000, 1'b0},
    {8'h23, 4'b0100, 1'b1}, {8'h23, 4'b1011, 1'b0},
    {8'h24, 4'b1011, 1'b1}, {8'h24, 4'b0100, 1'b0},
    {8'h25, 4'b0010, 1'b1}, {8'h25, 4'b1101, 1'b0},
    {8'h26, 4'b1101, 1'b1}, {8'h26, 4'b0010, 1'b0},
    {8'h27, 4'b0001, 1'b1}, {8'h27, 4'b1110, 1'b0},
    {8'h28, 4'b1110, 1'b1}, {8'h28, 4'b0001, 1'b0}
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = '{IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write,
          halted, ALU_Sel, Bus1_Sel, Bus2_Sel, mar};
    return o;
  endfunction

  function automatic int data_strobes();
    int s = 0;
    for (int i = 0; i < n_cyc; i++)
      s += int'(lg[i].a_l) + int'(lg[i].b_l) + int'(lg[i].pc_l) +
           int'(lg[i].ccr_l) + int'(lg[i].wr);
    return s;
  endfunction

  // Starts at a negedge in a live S_FETCH_0; returns at the next one.
  task automatic run_instr(input logic [3:0] flags);
    ccr   = flags;
    n_cyc = 0;
    do begin
      lg[n_cyc] = sample();
      n_cyc++;
      @(negedge clk);
    end while (!(dut.state == S_FETCH_0 && MAR_Load) && n_cyc < 20);
    check("instr_bound", 32'(n_cyc < 20), 32'd1);
  endtask

  initial begin
    logic [12:0] v;
    reset = 1'b1;
    ccr   = 4'b0000;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h86; mem[8'h01] = 8'h0F;   // LDA_IMM 15
    mem[8'h02] = 8'h89; mem[8'h03] = 8'hF0;   // LDB_DIR 0xF0
    mem[8'h04] = 8'h96; mem[8'h05] = 8'hE0;   // STA_DIR 0xE0
    mem[8'h06] = 8'h43;                       // SUB_AB
    mem[8'h07] = 8'h99;                       // illegal
    mem[8'h08] = 8'h21; mem[8'h09] = 8'h20;   // BMI 0x20 (taken)
    mem[8'h20] = 8'h21; mem[8'h21] = 8'h30;   // BMI 0x30 (not taken)
    for (int i = 0; i < 18; i++) begin
      v = BV[i];
      mem[8'h22 + 2*i] = v[12:5];
      mem[8'h23 + 2*i] = 8'(8'h24 + 2*i);
    end
    mem[8'h46] = 8'h97; mem[8'h47] = 8'hE1;   // STB_DIR 0xE1
    mem[8'hF0] = 8'h05;
    mem[8'hE1] = 8'h77;

    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(dut.state), 32'(S_FETCH_0));
    check("rst_loads", {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load}, 0);
    check("rst_sels", {ALU_Sel, Bus1_Sel, Bus2_Sel}, 0);
    check("rst_write", 32'(write), 0);
    check("rst_halted", 32'(halted), 0);

    reset = 1'b1;
    @(negedge clk);
    check("first_mar_load", {MAR_Load, Bus1_Sel, Bus2_Sel}, {1'b1, 2'd0, 2'd1});

    // LDA_IMM 15
    run_instr(4'b0000);
    check("lda_cycles", n_cyc, 7);
    check("lda_load", {lg[6].a_l, lg[6].b2}, {1'b1, 2'd2});
    check("lda_pc", pc, 8'h02);
    check("lda_a", a, 8'h0F);

    // LDB_DIR 0xF0
    run_instr(4'b0000);
    check("ldb_cycles", n_cyc, 9);
    check("ldb_mar", lg[7].mar, 8'hF0);
    check("ldb_load", {lg[8].b_l, lg[8].a_l, lg[8].b2}, {1'b1, 1'b0, 2'd2});
    check("ldb_b", b, 8'h05);

    // STA_DIR 0xE0
    run_instr(4'b0000);
    check("sta_cycles", n_cyc, 8);
    check("sta_write", {lg[7].wr, lg[7].b1}, {1'b1, 2'd1});
    check("sta_one_write", data_strobes(), 1);
    check("sta_mem", mem[8'hE0], 8'h0F);

    // SUB_AB
    run_instr(4'b0000);
    check("sub_cycles", n_cyc, 5);
    check("sub_ctrl", {lg[4].alu, lg[4].a_l, lg[4].b_l, lg[4].ccr_l, lg[4].b1, lg[4].b2},
          {4'd3, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0});
    check("sub_a", a, 8'h0A);

    // Illegal opcode 0x99
    run_instr(4'b0000);
    check("ill_cycles", n_cyc, 4);
    check("ill_strobes", data_strobes(), 0);
    check("ill_pc", pc, 8'h08);

    // BMI taken (N=1) and not taken (N=0)
    run_instr(4'b1000);
    check("bmi_t_cycles", n_cyc, 7);
    check("bmi_t_ctrl", {lg[5].pc_i, lg[6].pc_l, lg[6].b2}, {1'b0, 1'b1, 2'd2});
    check("bmi_t_pc", pc, 8'h20);
    run_instr(4'b0111);
    check("bmi_nt_cycles", n_cyc, 5);
    check("bmi_nt_inc", {lg[4].pc_i, lg[4].pc_l}, {1'b1, 1'b0});
    check("bmi_nt_pc", pc, 8'h22);

    // All branches, condition true and false
    for (int i = 0; i < 18; i++) begin
      v = BV[i];
      run_instr(v[4:1]);
      check($sformatf("br_%0h_%b_cycles", v[12:5], v[4:1]), n_cyc, v[0] ? 7 : 5);
      check($sformatf("br_%0h_%b_pcload", v[12:5], v[4:1]), data_strobes(), v[0] ? 1 : 0);
      check($sformatf("br_%0h_%b_pc", v[12:5], v[4:1]), pc, 8'(8'h24 + 2*i));
    end

    // STB_DIR interrupted by reset in S_DIR_7
    repeat (7) @(negedge clk);
    check("stb_write_live", {write, Bus1_Sel}, {1'b1, 2'd2});
    reset = 1'b0;
    #1;
    check("rst_mid_write", 32'(write), 0);
    check("rst_mid_state", 32'(dut.state), 32'(S_FETCH_0));
    @(negedge clk);
    check("rst_no_store", mem[8'hE1], 8'h77);
    mem[8'h00] = 8'h00;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_mar", 32'(MAR_Load), 1);

`ifdef CU_HALT_EN
    begin
      int bad;
      bad = 0;
      repeat (4) @(negedge clk);
      check("halt_enter", 32'(halted), 1);
      repeat (100) begin
        @(negedge clk);
        if (halted !== 1'b1 || dut.state != S_HALT ||
            {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write} !== 8'h00)
          bad++;
      end
      check("halt_hold", bad, 0);
      reset = 1'b0;
      #1;
      check("halt_reset", 32'(halted), 0);
      reset = 1'b1;
    end
`else
    run_instr(4'b0000);
    check("nop00_cycles", n_cyc, 4);
    check("nop00_strobes", data_strobes(), 0);
    check("nop00_halted", 32'(halted), 0);
    check("nop00_pc", pc, 8'h01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
